// File: rtl/logic_unit_8_bits_arbiter.sv
// logic_unit_8_bits_arbiter
// Shares one external gate-level 8-bit logic unit (NOT/AND/OR/XOR) between
// two valid/ready requesters. Round-robin arbitration picks a requester in
// IDLE. Its operands are held on the datapath for EXEC_CYCLES edges. The
// result is then returned on one response channel, tagged with the owner id.
// Optional build macro: LU_SELF_CHECK_EN -- adds an internal reference model
// and a sticky check_err flag that is raised when the external unit's result
// disagrees with the model at the capture edge.
module logic_unit_8_bits_arbiter #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       lu_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_s,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic             check_err
);

  localparam int               CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last_grant;
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_lu_op;
  logic [WIDTH-1:0] r_lu_a;
  logic [WIDTH-1:0] r_lu_b;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_resp_data;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_capture;
  logic             w_resp_done;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Round-robin grant, offered only in IDLE and never while reset is held.
  // NOTE: every always_comb output is given a default first, so no latch is inferred.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if ((r_state == IDLE) && rst_n) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  // A grant is only ever given to a valid requester, so grant means handshake.
  assign w_accept    = w_grant0 | w_grant1;
  assign w_capture   = (r_state == EXEC) && (r_cnt == '0);
  assign w_resp_done = (r_state == RESP) && resp_ready;
  assign w_sel_op    = w_grant1 ? req1_op : req0_op;
  assign w_sel_a     = w_grant1 ? req1_a  : req0_a;
  assign w_sel_b     = w_grant1 ? req1_b  : req0_b;

  // Next-state selection.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_next = EXEC;
      EXEC:    if (w_capture) w_state_next = RESP;
      RESP:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, grant history, settle counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_lu_op      <= '0;
      r_lu_a       <= '0;
      r_lu_b       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_lu_op      <= w_sel_op;
        r_lu_a       <= w_sel_a;
        r_lu_b       <= w_sel_b;
        r_owner      <= w_grant1;
        r_last_grant <= w_grant1;
        r_cnt        <= CNT_LOAD;
      end else if ((r_state == EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_capture) begin
        r_resp_data  <= lu_s;
        r_resp_id    <= r_owner;
        r_resp_valid <= 1'b1;
      end else if (w_resp_done) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign lu_op      = r_lu_op;
  assign lu_a       = r_lu_a;
  assign lu_b       = r_lu_b;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = (r_state != IDLE);

`ifdef LU_SELF_CHECK_EN
  logic [WIDTH-1:0] w_expected;
  logic             r_check_err;

  // Reference result computed from the operands currently on the datapath.
  always_comb begin
    w_expected = '0;
    case (r_lu_op)
      2'b00:   w_expected = ~r_lu_a;
      2'b01:   w_expected = r_lu_a & r_lu_b;
      2'b10:   w_expected = r_lu_a | r_lu_b;
      default: w_expected = r_lu_a ^ r_lu_b;
    endcase
  end

  // Sticky mismatch flag, evaluated only at the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_check_err <= 1'b0;
    else if (w_capture && (lu_s != w_expected)) r_check_err <= 1'b1;
  end

  assign check_err = r_check_err;
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_8_bits_arbiter.sv
// Bench for logic_unit_8_bits_arbiter. Two instances: index 0 uses
// EXEC_CYCLES=1, index 1 uses EXEC_CYCLES=3. Each has a transaction-level
// reference model and a per-cycle compare process; directed sequences add
// literal expectations, then randomized traffic runs on both instances.
module tb_logic_unit_8_bits_arbiter;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;
`ifdef LU_SELF_CHECK_EN
  localparam bit SELF_CHK = 1'b1;
`else
  localparam bit SELF_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n      [2];
  logic       valid      [2][2];
  logic       ready      [2][2];
  logic [1:0] op         [2][2];
  logic [7:0] a          [2][2];
  logic [7:0] b          [2][2];
  logic [1:0] lu_op      [2];
  logic [7:0] lu_a       [2];
  logic [7:0] lu_b       [2];
  logic [7:0] lu_s       [2];
  logic       resp_valid [2];
  logic       resp_ready [2];
  logic       resp_id    [2];
  logic [7:0] resp_data  [2];
  logic       busy       [2];
  logic       check_err  [2];
  logic       inj_en     [2];
  logic [7:0] inj_val    [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Function of the external logic unit.
  function automatic logic [7:0] lu_fn(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'b00:   return ~x;
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  // Who may be granted when idle: bit0 = requester 0, bit1 = requester 1.
  function automatic logic [1:0] grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int EXEC = (g == 0) ? 1 : 3;
    wire        w_rst_n = rst_n[g];
    logic       m_inflight, m_rv, m_owner, m_last, m_rid, m_err;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b, m_rdata;
    int         m_cyc, m_t_acc;
    logic [1:0] w_gr;

    logic_unit_8_bits_arbiter #(.WIDTH(8), .EXEC_CYCLES(EXEC)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req0_valid (valid[g][0]),
      .req0_ready (ready[g][0]),
      .req0_op    (op[g][0]),
      .req0_a     (a[g][0]),
      .req0_b     (b[g][0]),
      .req1_valid (valid[g][1]),
      .req1_ready (ready[g][1]),
      .req1_op    (op[g][1]),
      .req1_a     (a[g][1]),
      .req1_b     (b[g][1]),
      .lu_op      (lu_op[g]),
      .lu_a       (lu_a[g]),
      .lu_b       (lu_b[g]),
      .lu_s       (lu_s[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_id    (resp_id[g]),
      .resp_data  (resp_data[g]),
      .busy       (busy[g]),
      .check_err  (check_err[g])
    );

    // External logic unit, with an optional forced (wrong) result.
    assign lu_s[g] = inj_en[g] ? inj_val[g] : lu_fn(lu_op[g], lu_a[g], lu_b[g]);
    assign w_gr    = grant(valid[g][0], valid[g][1], m_last);

    // Transaction model: accept -> result due EXEC edges later -> held until taken.
    always @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        m_inflight <= 1'b0; m_rv <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
        m_rid <= 1'b0; m_err <= 1'b0; m_op <= '0; m_a <= '0; m_b <= '0;
        m_rdata <= '0; m_cyc <= 0; m_t_acc <= 0;
      end else begin
        if (!m_inflight) begin
          if (w_gr != 2'b00) begin
            m_inflight <= 1'b1;
            m_owner    <= w_gr[1];
            m_last     <= w_gr[1];
            m_op       <= w_gr[1] ? op[g][1] : op[g][0];
            m_a        <= w_gr[1] ? a[g][1]  : a[g][0];
            m_b        <= w_gr[1] ? b[g][1]  : b[g][0];
            m_t_acc    <= m_cyc;
          end
        end else if (!m_rv) begin
          if (m_cyc == m_t_acc + EXEC) begin
            m_rv    <= 1'b1;
            m_rdata <= lu_s[g];
            m_rid   <= m_owner;
            m_err   <= m_err | (lu_s[g] != lu_fn(m_op, m_a, m_b));
          end
        end else if (resp_ready[g]) begin
          m_rv       <= 1'b0;
          m_inflight <= 1'b0;
        end
        m_cyc <= m_cyc + 1;
      end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
      check($sformatf("i%0d resp_valid", g), 32'(resp_valid[g]), 32'(m_rv));
      check($sformatf("i%0d resp_id", g),    32'(resp_id[g]),    32'(m_rid));
      check($sformatf("i%0d resp_data", g),  32'(resp_data[g]),  32'(m_rdata));
      check($sformatf("i%0d lu_op", g),      32'(lu_op[g]),      32'(m_op));
      check($sformatf("i%0d lu_a", g),       32'(lu_a[g]),       32'(m_a));
      check($sformatf("i%0d lu_b", g),       32'(lu_b[g]),       32'(m_b));
      check($sformatf("i%0d busy", g),       32'(busy[g]),       32'(m_inflight));
      check($sformatf("i%0d check_err", g),  32'(check_err[g]),  32'(SELF_CHK & m_err));
      check($sformatf("i%0d req0_ready", g), 32'(ready[g][0]),
            32'(w_rst_n & ~m_inflight & w_gr[0]));
      check($sformatf("i%0d req1_ready", g), 32'(ready[g][1]),
            32'(w_rst_n & ~m_inflight & w_gr[1]));
      check($sformatf("i%0d both_ready", g), 32'(ready[g][0] & ready[g][1]), 32'(0));
    end
  end

  // Present a request and hold it until granted; drop valid after the accept edge.
  task automatic issue(input int k, input int r, input logic [1:0] o,
                       input logic [7:0] xa, input logic [7:0] xb);
    bit got;
    got = 1'b0;
    op[k][r] = o; a[k][r] = xa; b[k][r] = xb; valid[k][r] = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (ready[k][r]) got = 1'b1;
    end
    check($sformatf("i%0d r%0d granted in time", k, r), 32'(got), 32'(1));
    @(posedge clk); #1;
    valid[k][r] = 1'b0;
  endtask

  // Wait (bounded) for a response; returns at a negedge with resp_valid high.
  task automatic wait_resp(input int k);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (resp_valid[k]) got = 1'b1;
    end
    check($sformatf("i%0d response in time", k), 32'(got), 32'(1));
  endtask

  task automatic pulse_reset(input int k);
    @(posedge clk); #1; rst_n[k] = 1'b0;
    @(posedge clk); #1; rst_n[k] = 1'b1;
  endtask

  logic [1:0] t_op  [4] = '{OP_NOT, OP_NOT, OP_AND, OP_XOR};
  logic [7:0] t_a   [4] = '{8'h99, 8'hF0, 8'hF0, 8'hAA};
  logic [7:0] t_b   [4] = '{8'h00, 8'h00, 8'h3C, 8'hFF};
  logic [7:0] t_exp [4] = '{8'h66, 8'h0F, 8'h30, 8'h55};

  initial begin
    int n_lat;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; resp_ready[k] = 1'b1; inj_en[k] = 1'b0; inj_val[k] = '0;
      for (int r = 0; r < 2; r++) begin
        valid[k][r] = 1'b0; op[k][r] = '0; a[k][r] = '0; b[k][r] = '0;
      end
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst resp_valid", 32'(resp_valid[0]), 32'(0));
    check("rst busy",       32'(busy[0]),       32'(0));
    check("rst lu_a",       32'(lu_a[0]),       32'(0));
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // NOT 0xFF: result one edge after accept, busy until the handshake.
    issue(0, 0, OP_NOT, 8'hFF, 8'h00);
    @(negedge clk);
    check("t1 busy after accept", 32'(busy[0]),       32'(1));
    check("t1 no resp yet",       32'(resp_valid[0]), 32'(0));
    @(negedge clk);
    check("t1 resp_valid",        32'(resp_valid[0]), 32'(1));
    check("t1 resp_id",           32'(resp_id[0]),    32'(0));
    check("t1 resp_data",         32'(resp_data[0]),  32'h00);
    check("t1 busy in resp",      32'(busy[0]),       32'(1));
    @(negedge clk);
    check("t1 resp done",         32'(resp_valid[0]), 32'(0));
    check("t1 idle",              32'(busy[0]),       32'(0));

    // Single requests on requester 0.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      issue(0, 0, t_op[i], t_a[i], t_b[i]);
      wait_resp(0);
      check($sformatf("single%0d data", i), 32'(resp_data[0]), 32'(t_exp[i]));
      check($sformatf("single%0d id", i),   32'(resp_id[0]),   32'(0));
    end
    @(posedge clk); #1;

    // Both requesters continuously valid: strict alternation from 0.
    pulse_reset(0);
    op[0][0] = OP_OR;  a[0][0] = 8'h0F; b[0][0] = 8'hF0; valid[0][0] = 1'b1;
    op[0][1] = OP_NOT; a[0][1] = 8'h00; b[0][1] = 8'h5A; valid[0][1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_resp(0);
      check($sformatf("alt%0d id", i),   32'(resp_id[0]),   32'(i % 2));
      check($sformatf("alt%0d data", i), 32'(resp_data[0]), 32'hFF);
      @(posedge clk); #1;
    end
    valid[0][0] = 1'b0; valid[0][1] = 1'b0;

    // Response back-pressure for several cycles with both requesters waiting.
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    issue(0, 0, OP_AND, 8'hF0, 8'h3C);
    valid[0][0] = 1'b1; valid[0][1] = 1'b1;
    wait_resp(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d valid", i), 32'(resp_valid[0]), 32'(1));
      check($sformatf("stall%0d id", i),    32'(resp_id[0]),    32'(0));
      check($sformatf("stall%0d data", i),  32'(resp_data[0]),  32'h30);
      check($sformatf("stall%0d rdy", i),   32'(ready[0][0] | ready[0][1]), 32'(0));
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check("stall release pending", 32'(resp_valid[0]), 32'(1));
    @(posedge clk); #1;
    valid[0][0] = 1'b0; valid[0][1] = 1'b0;
    @(negedge clk);
    check("stall release done", 32'(resp_valid[0]), 32'(0));
    check("stall release idle", 32'(busy[0]),       32'(0));

    // Forced wrong result from the logic unit.
    @(posedge clk); #1;
    inj_en[0] = 1'b1; inj_val[0] = 8'h01;
    issue(0, 0, OP_NOT, 8'h00, 8'h00);
    wait_resp(0);
    check("inj data carries lu_s", 32'(resp_data[0]), 32'h01);
    @(posedge clk); #1;
    inj_en[0] = 1'b0;
    @(negedge clk);
    check("inj check_err set", 32'(check_err[0]), 32'(SELF_CHK));
    @(posedge clk); #1;
    issue(0, 0, OP_XOR, 8'hAA, 8'hFF);
    wait_resp(0);
    check("inj later data",    32'(resp_data[0]), 32'h55);
    check("inj check_err kept", 32'(check_err[0]), 32'(SELF_CHK));
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    #1;
    check("inj check_err cleared", 32'(check_err[0]), 32'(0));
    @(posedge clk); #1;
    rst_n[0] = 1'b1;

    // EXEC_CYCLES=3: reset during the second EXEC cycle.
    issue(1, 1, OP_XOR, 8'h5A, 8'hC3);
    @(posedge clk); #2;
    rst_n[1] = 1'b0;
    #1;
    check("mid rst busy",      32'(busy[1]),       32'(0));
    check("mid rst lu_op",     32'(lu_op[1]),      32'(0));
    check("mid rst lu_a",      32'(lu_a[1]),       32'(0));
    check("mid rst lu_b",      32'(lu_b[1]),       32'(0));
    check("mid rst resp_valid", 32'(resp_valid[1]), 32'(0));
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post rst%0d no resp", i), 32'(resp_valid[1]), 32'(0));
    end
    @(posedge clk); #1;
    issue(1, 0, OP_OR, 8'h81, 8'h18);
    n_lat = 1;
    @(posedge clk); #1;
    while (!resp_valid[1] && n_lat < 20) begin
      @(posedge clk); #1;
      n_lat++;
    end
    check("exec3 latency", 32'(n_lat), 32'(3));
    check("exec3 data",    32'(resp_data[1]), 32'h99);
    @(posedge clk); #1;

    // Randomized traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        rst_n[k]      = ($urandom_range(0, 199) != 0);
        resp_ready[k] = ($urandom_range(0, 9) < 7);
        inj_en[k]     = ($urandom_range(0, 49) == 0);
        inj_val[k]    = 8'($urandom);
        for (int r = 0; r < 2; r++) begin
          valid[k][r] = ($urandom_range(0, 9) < 6);
          op[k][r]    = 2'($urandom);
          a[k][r]     = 8'($urandom);
          b[k][r]     = 8'($urandom);
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b1; resp_ready[k] = 1'b1; inj_en[k] = 1'b0;
      valid[k][0] = 1'b0; valid[k][1] = 1'b0;
    end
    repeat (10) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
